i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Shares the single-byte I2C master between NUM_REQ requesters using round-robin arbitration.
- Sequences each transaction by releasing the master from reset, watching its state output until DONE, capturing the read byte, then re-asserting master reset to return it to IDLE.
- Provides timeout recovery when the slave never ACKs or the master stalls.
- Sits between the system request logic and the I2C master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of done_id; must be at least clog2(NUM_REQ).
- TO_W, 8, width of the transaction timeout counter.
- TIMEOUT_CYC, 200, cycles allowed in RUN before abort; must be below 2^TO_W.
- RST_HOLD, 2, cycles mst_rst is held high in RELEASE; must be at least 1.
- MST_DONE, 3'd5, master state encoding that signals transaction complete.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_rw  in  NUM_REQ  per-requester direction; 1 = read, 0 = write.
- req_wdata  in  8*NUM_REQ  write byte; requester i uses bits [8i+7:8i].
- gnt  out  NUM_REQ  one-hot grant, high for the whole transaction.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  ID_W  index of the completed requester; valid while done is high.
- rdata  out  8  captured read byte; holds until the next read completes.
- err  out  1  one-cycle pulse, coincident with done, when the transaction timed out.
- mst_rst  out  1  active-high reset to the master.
- mst_rw  out  1  direction to the master.
- mst_data_in  out  8  write byte to the master.
- mst_data_out  in  8  read byte from the master.
- mst_state  in  3  master state.

Behaviour:
- Reset (rst=0 at posedge), forced regardless of state:
  - FSM goes to IDLE.
  - gnt=0, busy=0, done=0, err=0, rdata=8'h00, done_id=0.
  - mst_rst=1, mst_rw=0, mst_data_in=8'h00.
  - Round-robin pointer resets to NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction aborts it with no done pulse.
- FSM states: IDLE, LAUNCH, RUN, RELEASE.
- IDLE:
  - mst_rst=1.
  - If any req bit is set, pick the winner: search from index ptr+1 upward, wrapping modulo NUM_REQ; the first set bit wins.
  - Register gnt (one-hot), mst_rw=req_rw[w] and mst_data_in=req_wdata[w]; these stay stable until RELEASE exits.
  - Next state LAUNCH. gnt rises at the cycle after req is seen.
- LAUNCH:
  - mst_rst=0, timer cleared; next state RUN.
  - The master's first un-reset edge is the posedge following LAUNCH.
- RUN:
  - mst_rst=0 and the timer increments each cycle.
  - If mst_state==MST_DONE: rdata=mst_data_out when mst_rw=1 (unchanged for writes), done=1, done_id=w, next state RELEASE.
  - Else if timer==TIMEOUT_CYC-1: done=1, err=1, done_id=w, rdata unchanged, next state RELEASE.
  - If DONE and timeout occur on the same cycle, DONE wins and err=0.
- RELEASE:
  - mst_rst=1 for exactly RST_HOLD cycles; done and err are low here.
  - On exit: gnt=0, ptr=w, next state IDLE.
- Minimum spacing between back-to-back grants is RST_HOLD+1 cycles after done.
- Handshake rules:
  - A requester holds req until it sees done with done_id equal to its own index.
  - req is sampled only in IDLE; dropping req mid-transaction does not abort, and the transaction still completes with done.
  - req_rw and req_wdata must be stable on the cycle the request is granted.
- Invariants:
  - gnt is never multi-hot.
  - busy=1 exactly in LAUNCH, RUN and RELEASE.
  - mst_rst=0 only in LAUNCH and RUN.

Test Plan:
- Read by req0: req=4'b0001, req_rw[0]=1, slave ACKs and returns 8'hA5.
  -> gnt=4'b0001 one cycle later; one done pulse with done_id=0, rdata=8'hA5, err=0; mst_rst high for 2 cycles, then busy=0.
- Simultaneous writes: req=4'b0110 with wdata 8'h11 for req1 and 8'h22 for req2.
  -> req1 served first with mst_data_in=8'h11, then req2 with 8'h22; two done pulses with done_id 1 then 2.
- Fairness: all four requesters held high for 8 transactions.
  -> grant order 0,1,2,3,0,1,2,3 and gnt always one-hot.
- No ACK: slave leaves sda high, so the master never reaches state 5.
  -> exactly 200 cycles in RUN, then done=1 and err=1 together, rdata unchanged, master re-reset, FSM back to IDLE.
- Reset mid-RUN: assert rst=0 for 1 cycle during addressing.
  -> next cycle gnt=0, busy=0, mst_rst=1, no done pulse; a subsequent req0 is served normally.
- Drop req mid-transaction: req3 deasserted during RUN.
  -> transaction still completes with done_id=3; no regrant to req3 afterwards.

Source files
------------

// File: rtl/i2c_txn_arbiter_if.sv
// Bundle of request-side and I2C-master-side signals around the transaction arbiter.
// The slave modport is the arbiter's view; master is the surrounding system/master view.
interface i2c_txn_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_rw;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic                 busy;
  logic                 done;
  logic [ID_W-1:0]      done_id;
  logic [7:0]           rdata;
  logic                 err;
  logic                 mst_rst;
  logic                 mst_rw;
  logic [7:0]           mst_data_in;
  logic [7:0]           mst_data_out;
  logic [2:0]           mst_state;

  modport slave (
    input  req, req_rw, req_wdata, mst_data_out, mst_state,
    output gnt, busy, done, done_id, rdata, err, mst_rst, mst_rw, mst_data_in
  );

  modport master (
    output req, req_rw, req_wdata, mst_data_out, mst_state,
    input  gnt, busy, done, done_id, rdata, err, mst_rst, mst_rw, mst_data_in
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one single-byte I2C master among NUM_REQ requesters,
// sequencing master reset release, completion/timeout detection and re-reset.
module i2c_txn_arbiter #(
  parameter int       NUM_REQ     = 4,
  parameter int       ID_W        = 2,
  parameter int       TO_W        = 8,
  parameter int       TIMEOUT_CYC = 200,
  parameter int       RST_HOLD    = 2,
  parameter logic [2:0] MST_DONE  = 3'd5
) (
  input  logic clk,
  input  logic rst,
  i2c_txn_arbiter_if.slave bus
);

  localparam int SW = ID_W + 1;
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_RELEASE
  } state_e;

  state_e               state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [ID_W-1:0]      done_id_q;
  logic [7:0]           rdata_q;
  logic                 mst_rst_q;
  logic                 mst_rw_q;
  logic [7:0]           mst_wdata_q;
  logic [ID_W-1:0]      win_q;
  logic [ID_W-1:0]      ptr_q;
  logic [TO_W-1:0]      timer_q;
  logic [HW-1:0]        hold_q;

  logic [ID_W-1:0]      cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]   cand_hit;
  logic [7:0]           wbyte [NUM_REQ];
  logic                 win_vld_d;
  logic [ID_W-1:0]      win_d;

  // Candidate gi is the requester gi+1 places after the last winner, wrapped.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [SW-1:0] sum;
    assign sum           = SW'(ptr_q) + SW'(gi + 1);
    assign cand_idx[gi]  = (sum >= SW'(NUM_REQ)) ? ID_W'(sum - SW'(NUM_REQ)) : ID_W'(sum);
    assign cand_hit[gi]  = bus.req[cand_idx[gi]];
    assign wbyte[gi]     = bus.req_wdata[8*gi +: 8];
  end

  always_comb begin
    win_vld_d = 1'b0;
    win_d     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        win_vld_d = 1'b1;
        win_d     = cand_idx[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      done_id_q   <= '0;
      rdata_q     <= 8'h00;
      mst_rst_q   <= 1'b1;
      mst_rw_q    <= 1'b0;
      mst_wdata_q <= 8'h00;
      win_q       <= '0;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      timer_q     <= '0;
      hold_q      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          mst_rst_q <= 1'b1;
          if (win_vld_d) begin
            gnt_q       <= NUM_REQ'(1) << win_d;
            win_q       <= win_d;
            mst_rw_q    <= bus.req_rw[win_d];
            mst_wdata_q <= wbyte[win_d];
            busy_q      <= 1'b1;
            mst_rst_q   <= 1'b0;
            state_q     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          timer_q <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          // Completion is checked before the timeout so a same-cycle DONE is not an error.
          if (bus.mst_state == MST_DONE) begin
            if (mst_rw_q) begin
              rdata_q <= bus.mst_data_out;
            end
            done_q    <= 1'b1;
            done_id_q <= win_q;
            mst_rst_q <= 1'b1;
            hold_q    <= '0;
            state_q   <= ST_RELEASE;
          end else if (timer_q == TO_W'(TIMEOUT_CYC - 1)) begin
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            done_id_q <= win_q;
            mst_rst_q <= 1'b1;
            hold_q    <= '0;
            state_q   <= ST_RELEASE;
          end else begin
            timer_q <= timer_q + TO_W'(1);
          end
        end
        ST_RELEASE: begin
          if (hold_q == HW'(RST_HOLD - 1)) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= win_q;
            state_q <= ST_IDLE;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.done_id     = done_id_q;
  assign bus.rdata       = rdata_q;
  assign bus.err         = err_q;
  assign bus.mst_rst     = mst_rst_q;
  assign bus.mst_rw      = mst_rw_q;
  assign bus.mst_data_in = mst_wdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: directed requests, a behavioural master stand-in,
// and a negedge monitor that checks grants and completions against queued expectations.
module tb_i2c_txn_arbiter;

  localparam int RST_HOLD = 2;

  typedef struct {
    int         idx;
    logic       rw;
    logic [7:0] wdata;
  } gnt_exp_t;

  typedef struct {
    int         id;
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } done_exp_t;

  logic clk = 1'b0;
  logic rst;

  gnt_exp_t  gnt_q_exp [$];
  done_exp_t done_q_exp [$];

  int errors = 0;
  int checks = 0;

  int         lat_cfg   = 4;
  logic       noack_cfg = 1'b0;
  logic [7:0] data_cfg  = 8'h00;
  logic [2:0] m_state   = 3'd0;
  int         m_cnt     = 0;
  logic [7:0] exp_rd;

  i2c_txn_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  i2c_txn_arbiter #(
    .NUM_REQ(4), .ID_W(2), .TO_W(8), .TIMEOUT_CYC(200), .RST_HOLD(RST_HOLD), .MST_DONE(3'd5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Master stand-in: reaches state 5 lat_cfg edges after leaving reset, or stalls in 3.
  always @(posedge clk) begin
    if (bus.mst_rst) begin
      m_cnt   <= 0;
      m_state <= 3'd0;
    end else if (m_state == 3'd5) begin
      m_state <= 3'd5;
    end else if (noack_cfg) begin
      m_state <= 3'd3;
    end else if (m_cnt == lat_cfg - 1) begin
      m_state <= 3'd5;
    end else begin
      m_cnt   <= m_cnt + 1;
      m_state <= 3'd1;
    end
  end

  assign bus.mst_state    = m_state;
  assign bus.mst_data_out = data_cfg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_gnt(input int idx, input logic rw, input logic [7:0] wd);
    gnt_exp_t g;
    g.idx = idx; g.rw = rw; g.wdata = wd;
    gnt_q_exp.push_back(g);
  endtask

  task automatic push_done(input int id, input logic [7:0] rd, input logic e, input int lat);
    done_exp_t d;
    d.id = id; d.rdata = rd; d.err = e; d.lat = lat;
    done_q_exp.push_back(d);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 600 cycles");
    end
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.gnt == 4'b0000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.gnt == 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: got gnt=0 expected a grant within 100 cycles");
    end
  endtask

  // Monitor: grant rise and done pulse are compared against the expectation queues.
  initial begin
    int cyc, gnt_cyc, done_cyc, gi;
    logic [3:0] prev_gnt;
    logic prev_busy, prev_done, rel_pending;
    gnt_exp_t  g;
    done_exp_t d;
    cyc = 0; gnt_cyc = 0; done_cyc = 0;
    prev_gnt = 4'b0; prev_busy = 1'b0; prev_done = 1'b0; rel_pending = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        rel_pending = 1'b0;
      end else begin
        checks++;
        if (!$onehot0(bus.gnt) || (!bus.busy && (!bus.mst_rst || bus.gnt != 4'b0))
            || (bus.err && !bus.done) || (bus.done && prev_done)) begin
          errors++;
          $display("FAIL invariant: got gnt=%b busy=%b mst_rst=%b done=%b err=%b expected legal combination",
                   bus.gnt, bus.busy, bus.mst_rst, bus.done, bus.err);
        end
        if (bus.gnt != 4'b0 && prev_gnt == 4'b0) begin
          gnt_cyc = cyc;
          gi = 0;
          for (int i = 0; i < 4; i++) if (bus.gnt[i]) gi = i;
          if (gnt_q_exp.size() == 0) begin
            chk("unexpected_gnt", {28'b0, bus.gnt}, 32'h0);
          end else begin
            g = gnt_q_exp.pop_front();
            chk("gnt_idx", gi, g.idx);
            chk("gnt_mst_rw", {31'b0, bus.mst_rw}, {31'b0, g.rw});
            chk("gnt_mst_data_in", {24'b0, bus.mst_data_in}, {24'b0, g.wdata});
            chk("gnt_mst_rst", {31'b0, bus.mst_rst}, 32'h0);
          end
        end
        if (bus.done) begin
          done_cyc = cyc;
          rel_pending = 1'b1;
          $display("txn done id=%0d rdata=%02h err=%0d lat=%0d", bus.done_id, bus.rdata, bus.err, cyc - gnt_cyc);
          if (done_q_exp.size() == 0) begin
            chk("unexpected_done", {31'b0, bus.done}, 32'h0);
          end else begin
            d = done_q_exp.pop_front();
            chk("done_id", {30'b0, bus.done_id}, d.id);
            chk("done_rdata", {24'b0, bus.rdata}, {24'b0, d.rdata});
            chk("done_err", {31'b0, bus.err}, {31'b0, d.err});
            chk("done_latency", cyc - gnt_cyc, d.lat);
            chk("done_mst_rst", {31'b0, bus.mst_rst}, 32'h1);
          end
        end
        if (prev_busy && !bus.busy && rel_pending) begin
          chk("release_len", cyc - done_cyc, RST_HOLD);
          rel_pending = 1'b0;
        end
      end
      prev_gnt  = bus.gnt;
      prev_busy = bus.busy;
      prev_done = bus.done;
    end
  end

  initial begin
    logic [3:0] rw_v;
    int i;
    rst = 1'b0;
    bus.req = 4'b0; bus.req_rw = 4'b0; bus.req_wdata = 32'h0;
    exp_rd = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {28'b0, bus.gnt}, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    chk("rst_err", {31'b0, bus.err}, 32'h0);
    chk("rst_rdata", {24'b0, bus.rdata}, 32'h0);
    chk("rst_done_id", {30'b0, bus.done_id}, 32'h0);
    chk("rst_mst_rst", {31'b0, bus.mst_rst}, 32'h1);
    chk("rst_mst_rw", {31'b0, bus.mst_rw}, 32'h0);
    chk("rst_mst_data_in", {24'b0, bus.mst_data_in}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Read by requester 0.
    data_cfg = 8'hA5; lat_cfg = 5;
    bus.req_rw = 4'b0001; bus.req_wdata = 32'h0000_003C;
    exp_rd = 8'hA5;
    push_gnt(0, 1'b1, 8'h3C);
    push_done(0, exp_rd, 1'b0, 6);
    bus.req = 4'b0001;
    wait_done();
    bus.req = 4'b0000;

    // Simultaneous writes from 1 and 2; rdata must hold A5.
    data_cfg = 8'hEE; lat_cfg = 3;
    bus.req_rw = 4'b0000; bus.req_wdata = 32'h0022_1100;
    push_gnt(1, 1'b0, 8'h11);
    push_gnt(2, 1'b0, 8'h22);
    push_done(1, exp_rd, 1'b0, 4);
    push_done(2, exp_rd, 1'b0, 4);
    bus.req = 4'b0110;
    wait_done();
    bus.req = 4'b0100;
    wait_done();
    bus.req = 4'b0000;

    // Requester 3 drops req mid-RUN; it must still complete and not be regranted.
    lat_cfg = 30;
    bus.req_wdata = 32'h9900_0000;
    push_gnt(3, 1'b0, 8'h99);
    push_done(3, exp_rd, 1'b0, 31);
    bus.req = 4'b1000;
    wait_gnt();
    repeat (5) @(negedge clk);
    bus.req = 4'b0000;
    wait_done();
    repeat (10) @(negedge clk);

    // Fairness with all four held; pointer is at 3 so order starts at 0.
    lat_cfg = 2; data_cfg = 8'h5A;
    rw_v = 4'b0101;
    bus.req_rw = rw_v; bus.req_wdata = 32'h4433_2211;
    for (int k = 0; k < 8; k++) begin
      i = k % 4;
      if (rw_v[i]) exp_rd = 8'h5A;
      push_gnt(i, rw_v[i], 8'(8'h11 * (i + 1)));
      push_done(i, exp_rd, 1'b0, 3);
    end
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) wait_done();
    bus.req = 4'b0000;
    repeat (5) @(negedge clk);

    // No ACK: timeout after 200 RUN cycles, rdata unchanged even for a read.
    noack_cfg = 1'b1; data_cfg = 8'hC3;
    bus.req_rw = 4'b0010;
    push_gnt(1, 1'b1, 8'h22);
    push_done(1, exp_rd, 1'b1, 201);
    bus.req = 4'b0010;
    wait_done();
    bus.req = 4'b0000;
    noack_cfg = 1'b0;
    repeat (5) @(negedge clk);

    // Reset mid-RUN aborts silently; next request is served normally.
    lat_cfg = 60;
    bus.req_rw = 4'b0001;
    push_gnt(0, 1'b1, 8'h11);
    bus.req = 4'b0001;
    wait_gnt();
    repeat (10) @(negedge clk);
    rst = 1'b0;
    bus.req = 4'b0000;
    @(negedge clk);
    chk("midrst_gnt", {28'b0, bus.gnt}, 32'h0);
    chk("midrst_busy", {31'b0, bus.busy}, 32'h0);
    chk("midrst_mst_rst", {31'b0, bus.mst_rst}, 32'h1);
    chk("midrst_done", {31'b0, bus.done}, 32'h0);
    chk("midrst_rdata", {24'b0, bus.rdata}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    lat_cfg = 3; data_cfg = 8'h7E;
    exp_rd = 8'h7E;
    push_gnt(0, 1'b1, 8'h11);
    push_done(0, exp_rd, 1'b0, 4);
    bus.req = 4'b0001;
    wait_done();
    bus.req = 4'b0000;

    repeat (20) @(negedge clk);
    chk("gnt_queue_empty", gnt_q_exp.size(), 0);
    chk("done_queue_empty", done_q_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
